// File: rtl/serial_transceiver.sv
`default_nettype none
// ============================================================================
// Module   : serial_transceiver
// Purpose  : Half-duplex UART-style link transceiver with clock-enable timing.
//            Optional even parity when SERIAL_PARITY_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module serial_transceiver #(
    parameter int DATA_W     = 8,
    parameter int SAMPLE_DIV = 128,
    parameter int OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              load,
    input  logic              transmit_enable,
    input  logic              serial_in,
    output logic              serial_out,
    output logic              serial_oe,
    output logic              tx_busy,
    output logic              character_sent,
    output logic [DATA_W-1:0] rx_data,
    output logic              character_received,
    output logic              framing_error
);

    localparam int BIT_T = SAMPLE_DIV * OVERSAMPLE;
    localparam int TW    = $clog2(BIT_T);
    localparam int DW    = $clog2(SAMPLE_DIV);
    localparam int OW    = $clog2(OVERSAMPLE);
    localparam int BW    = $clog2(DATA_W);

    localparam logic [TW-1:0] T_LAST    = TW'(BIT_T - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
    localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] HALF_LAST = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

    // ------------------------------------------------------------------ TX
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef SERIAL_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    tx_state_t         tx_state, tx_next;
    logic [TW-1:0]     tx_timer;
    logic [BW-1:0]     tx_bit;
    logic [DATA_W-1:0] tx_shift;
    logic              tx_accept;
    logic              tx_bit_end;
    logic              tx_line;
`ifdef SERIAL_PARITY_EN
    logic              tx_par;
`endif

    assign tx_accept  = (tx_state == TX_IDLE) && load && transmit_enable;
    assign tx_bit_end = (tx_timer == T_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tx_state <= TX_IDLE;
        else      tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        tx_line = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (tx_accept) tx_next = TX_START;
            end
            TX_START: begin
                tx_line = 1'b0;
                if (tx_bit_end) tx_next = TX_DATA;
            end
            TX_DATA: begin
                tx_line = tx_shift[0];
                if (tx_bit_end && tx_bit == BIT_LAST) begin
`ifdef SERIAL_PARITY_EN
                    tx_next = TX_PARITY;
`else
                    tx_next = TX_STOP;
`endif
                end
            end
`ifdef SERIAL_PARITY_EN
            TX_PARITY: begin
                tx_line = tx_par;
                if (tx_bit_end) tx_next = TX_STOP;
            end
`endif
            TX_STOP: begin
                if (tx_bit_end) tx_next = TX_IDLE;
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    // Line outputs lag the state by one clk so every pad signal is a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_timer       <= '0;
            tx_bit         <= '0;
            tx_shift       <= '0;
`ifdef SERIAL_PARITY_EN
            tx_par         <= 1'b0;
`endif
            serial_out     <= 1'b1;
            serial_oe      <= 1'b0;
            tx_busy        <= 1'b0;
            character_sent <= 1'b0;
        end else begin
            if (tx_accept) begin
                tx_timer <= '0;
                tx_bit   <= '0;
                tx_shift <= tx_data;
`ifdef SERIAL_PARITY_EN
                tx_par   <= ^tx_data;
`endif
            end else if (tx_state != TX_IDLE) begin
                tx_timer <= tx_bit_end ? '0 : tx_timer + 1'b1;
                if (tx_state == TX_DATA && tx_bit_end) begin
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= tx_bit + 1'b1;
                end
            end
            serial_out     <= tx_line;
            serial_oe      <= (tx_state != TX_IDLE);
            tx_busy        <= (tx_state != TX_IDLE);
            character_sent <= tx_busy && (tx_state == TX_IDLE);
        end
    end

    // ------------------------------------------------------------------ RX
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START_CHK,
        RX_DATA,
`ifdef SERIAL_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    rx_state_t         rx_state, rx_next;
    logic              sync0, sync1;
    logic [DW-1:0]     div;
    logic              tick;
    logic [OW-1:0]     rx_cnt;
    logic [BW-1:0]     rx_bit;
    logic [DATA_W-1:0] rx_shift;
    logic              rx_centre;
    logic              stop_ok;
`ifdef SERIAL_PARITY_EN
    logic              rx_par_err;
    assign stop_ok = sync1 & ~rx_par_err;
`else
    assign stop_ok = sync1;
`endif

    assign tick = (div == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync0 <= 1'b1;
            sync1 <= 1'b1;
            div   <= '0;
        end else begin
            sync0 <= serial_in;
            sync1 <= sync0;
            div   <= tick ? '0 : div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_state <= RX_IDLE;
        else      rx_state <= rx_next;
    end

    always_comb begin
        rx_next   = rx_state;
        rx_centre = 1'b0;
        case (rx_state)
            RX_START_CHK: rx_centre = tick && (rx_cnt == HALF_LAST);
            RX_DATA:      rx_centre = tick && (rx_cnt == OS_LAST);
`ifdef SERIAL_PARITY_EN
            RX_PARITY:    rx_centre = tick && (rx_cnt == OS_LAST);
`endif
            RX_STOP:      rx_centre = tick && (rx_cnt == OS_LAST);
            default:      rx_centre = 1'b0;
        endcase

        if (serial_oe) begin
            rx_next = RX_IDLE;
        end else begin
            case (rx_state)
                RX_IDLE:      if (tick && !sync1) rx_next = RX_START_CHK;
                RX_START_CHK: if (rx_centre) rx_next = sync1 ? RX_IDLE : RX_DATA;
                RX_DATA: begin
                    if (rx_centre && rx_bit == BIT_LAST) begin
`ifdef SERIAL_PARITY_EN
                        rx_next = RX_PARITY;
`else
                        rx_next = RX_STOP;
`endif
                    end
                end
`ifdef SERIAL_PARITY_EN
                RX_PARITY:    if (rx_centre) rx_next = RX_STOP;
`endif
                RX_STOP:      if (rx_centre) rx_next = stop_ok ? RX_IDLE : RX_WAIT_HIGH;
                RX_WAIT_HIGH: if (sync1) rx_next = RX_IDLE;
                default:      rx_next = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_cnt             <= '0;
            rx_bit             <= '0;
            rx_shift           <= '0;
            rx_data            <= '0;
            character_received <= 1'b0;
            framing_error      <= 1'b0;
`ifdef SERIAL_PARITY_EN
            rx_par_err         <= 1'b0;
`endif
        end else begin
            character_received <= 1'b0;
            framing_error      <= 1'b0;
            if (serial_oe || rx_state == RX_IDLE) begin
                rx_cnt <= '0;
                rx_bit <= '0;
            end else if (tick) begin
                rx_cnt <= rx_centre ? '0 : rx_cnt + 1'b1;
            end
            if (!serial_oe && rx_centre) begin
                case (rx_state)
                    RX_DATA: begin
                        rx_shift <= {sync1, rx_shift[DATA_W-1:1]};
                        rx_bit   <= rx_bit + 1'b1;
                    end
`ifdef SERIAL_PARITY_EN
                    RX_PARITY: rx_par_err <= sync1 ^ (^rx_shift);
`endif
                    RX_STOP: begin
                        if (stop_ok) begin
                            rx_data            <= rx_shift;
                            character_received <= 1'b1;
                        end else begin
                            framing_error      <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_transceiver.sv
`default_nettype none
// Bench for serial_transceiver: transmitter A loops its line into receiver B,
// the bench can also bit-bang the idle line to B.
module tb_serial_transceiver;

    localparam int DW = 8;
    localparam int SD = 4;
    localparam int OS = 8;
    localparam int T  = SD * OS;
`ifdef SERIAL_PARITY_EN
    localparam int F  = DW + 3;
`else
    localparam int F  = DW + 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] a_data = '0;
    logic          a_load = 1'b0;
    logic          a_en = 1'b0;
    logic          tb_line = 1'b1;
    logic          line;

    logic          a_out, a_oe, a_busy, a_sent, a_rcv, a_ferr;
    logic          b_out, b_oe, b_busy, b_sent, b_rcv, b_ferr;
    logic [DW-1:0] a_rx, b_rx;

    assign line = a_oe ? a_out : tb_line;

    serial_transceiver #(.DATA_W(DW), .SAMPLE_DIV(SD), .OVERSAMPLE(OS)) u_a (
        .clk(clk), .rst(rst), .tx_data(a_data), .load(a_load),
        .transmit_enable(a_en), .serial_in(line), .serial_out(a_out),
        .serial_oe(a_oe), .tx_busy(a_busy), .character_sent(a_sent),
        .rx_data(a_rx), .character_received(a_rcv), .framing_error(a_ferr)
    );

    serial_transceiver #(.DATA_W(DW), .SAMPLE_DIV(SD), .OVERSAMPLE(OS)) u_b (
        .clk(clk), .rst(rst), .tx_data(8'h00), .load(1'b0),
        .transmit_enable(1'b0), .serial_in(line), .serial_out(b_out),
        .serial_oe(b_oe), .tx_busy(b_busy), .character_sent(b_sent),
        .rx_data(b_rx), .character_received(b_rcv), .framing_error(b_ferr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame as a bit list: index i is the line level during bit period i.
    function automatic logic [F-1:0] make_frame(input logic [DW-1:0] d);
        logic [F-1:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < DW; i++) f[1+i] = d[i];
`ifdef SERIAL_PARITY_EN
        f[DW+1] = ^d;
`endif
        return f;
    endfunction

    // Transmit model: accept time plus elapsed cycles give every line value.
    int           cyc = 0;
    int           acc = -100000;
    int           age;
    logic [F-1:0] mframe = '1;
    logic         exp_oe = 1'b0, exp_out = 1'b1, exp_sent = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      = -100000;
            exp_oe   = 1'b0;
            exp_out  = 1'b1;
            exp_sent = 1'b0;
        end else begin
            cyc++;
            if (a_load && a_en && !(cyc - 1 - acc < F * T)) begin
                acc    = cyc;
                mframe = make_frame(a_data);
            end
            age      = cyc - acc;
            exp_oe   = (age >= 1) && (age <= F * T);
            exp_out  = exp_oe ? mframe[(age - 1) / T] : 1'b1;
            exp_sent = (age == F * T + 1);
        end
    end

    int            rcv_cnt = 0, ferr_cnt = 0, sent_cnt = 0, oe_cyc = 0;
    int            rcv_age = -1;
    logic [DW-1:0] prev_b_rx = '0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_tx", {28'd0, a_oe, a_out, a_busy, a_sent}, 32'b0100);
            chk("reset_rx", {22'd0, b_rcv, b_ferr, b_rx}, 32'd0);
        end else begin
            chk("tx_line", {28'd0, a_oe, a_out, a_busy, a_sent},
                {28'd0, exp_oe, exp_out, exp_oe, exp_sent});
            chk("b_tx_idle", {28'd0, b_oe, b_out, b_busy, b_sent}, 32'b0100);
            if (!b_rcv) chk("rx_hold", {24'd0, b_rx}, {24'd0, prev_b_rx});
            if (b_rcv) begin rcv_cnt++; rcv_age = cyc - acc; end
            if (b_ferr) ferr_cnt++;
            if (a_sent) sent_cnt++;
            if (a_oe) oe_cyc++;
        end
        prev_b_rx = b_rx;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        a_data = d;
        a_load = 1'b1;
        cycles(1);
        a_load = 1'b0;
    endtask

    task automatic bitbang(input logic [F-1:0] f);
        for (int i = 0; i < F; i++) begin
            tb_line = f[i];
            cycles(T);
        end
        tb_line = 1'b1;
    endtask

    localparam int LAT_LO = (F - 1) * T + T / 2 + 1;
    localparam int LAT_HI = (F - 1) * T + T / 2 + SD + 4;

    logic [F-1:0] lit;
    logic [F-1:0] fr;
    int           r0, f0, s0, o0;

    initial begin
        #2 rst = 1'b0;
        cycles(4);
        rst = 1'b1;
        cycles(8);

        // 0xA5 with line levels pinned at each bit centre.
`ifdef SERIAL_PARITY_EN
        lit = 11'b10100101010;
`else
        lit = 10'b1101001010;
`endif
        a_en = 1'b1;
        send(8'hA5);
        cycles(1);
        chk("oe_rise", {31'd0, a_oe}, 32'd1);
        cycles(T / 2);
        for (int i = 0; i < F; i++) begin
            chk("a5_bit", {31'd0, a_out}, {31'd0, lit[i]});
            cycles(T);
        end
        cycles(40);
        chk("a5_oe_cycles", oe_cyc, F * T);
        chk("a5_sent", sent_cnt, 1);
        chk("a5_rx", {24'd0, b_rx}, 32'hA5);
        chk("a5_rcv", rcv_cnt, 1);
        chk("a5_lat", {31'd0, (rcv_age >= LAT_LO) && (rcv_age <= LAT_HI)}, 32'd1);

        // Loopback 0x3C.
        send(8'h3C);
        cycles(F * T + 40);
        chk("3c_rx", {24'd0, b_rx}, 32'h3C);
        chk("3c_rcv", rcv_cnt, 2);
        chk("3c_ferr", ferr_cnt, 0);
        chk("3c_lat", {31'd0, (rcv_age >= LAT_LO) && (rcv_age <= LAT_HI)}, 32'd1);

        // Short low glitch is a false start.
        tb_line = 1'b0;
        cycles(8);
        tb_line = 1'b1;
        cycles(3 * T);
        chk("glitch_rcv", rcv_cnt, 2);
        chk("glitch_ferr", ferr_cnt, 0);

        // Bad stop bit, then a good frame.
        fr = make_frame(8'h55);
        fr[F-1] = 1'b0;
        bitbang(fr);
        cycles(T);
        chk("badstop_ferr", ferr_cnt, 1);
        chk("badstop_rcv", rcv_cnt, 2);
        chk("badstop_rx", {24'd0, b_rx}, 32'h3C);
        bitbang(make_frame(8'h0F));
        cycles(T);
        chk("0f_rx", {24'd0, b_rx}, 32'h0F);
        chk("0f_rcv", rcv_cnt, 3);
        chk("0f_ferr", ferr_cnt, 1);

`ifdef SERIAL_PARITY_EN
        send(8'h07);
        cycles(1 + (DW + 1) * T + T / 2);
        chk("par_bit", {31'd0, a_out}, 32'd1);
        cycles(3 * T);
        chk("par_rx", {24'd0, b_rx}, 32'h07);
        fr = make_frame(8'h07);
        fr[F-2] = ~fr[F-2];
        f0 = ferr_cnt;
        bitbang(fr);
        cycles(T);
        chk("par_err", ferr_cnt, f0 + 1);
        chk("par_err_rx", {24'd0, b_rx}, 32'h07);
`endif

        // Load held through busy, enable dropped mid-frame: one frame only.
        s0 = sent_cnt;
        a_data = 8'h81;
        a_load = 1'b1;
        cycles(100);
        a_en = 1'b0;
        cycles(100);
        a_load = 1'b0;
        cycles(F * T);
        chk("held_sent", sent_cnt, s0 + 1);
        chk("held_rx", {24'd0, b_rx}, 32'h81);
        o0 = oe_cyc;
        a_load = 1'b1;
        cycles(60);
        a_load = 1'b0;
        cycles(10);
        chk("dis_sent", sent_cnt, s0 + 1);
        chk("dis_oe", oe_cyc, o0);

        // Reset in the middle of bit 4.
        a_en = 1'b1;
        send(8'h5A);
        cycles(1 + 4 * T + 10);
        rst = 1'b0;
        #1;
        chk("mid_rst_tx", {28'd0, a_oe, a_out, a_busy, a_sent}, 32'b0100);
        chk("mid_rst_rx", {22'd0, b_rcv, b_ferr, b_rx}, 32'd0);
        cycles(3);
        rst = 1'b1;
        cycles(5);
        r0 = rcv_cnt;
        send(8'h12);
        cycles(F * T + 40);
        chk("post_rst_rx", {24'd0, b_rx}, 32'h12);
        chk("post_rst_rcv", rcv_cnt, r0 + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_transceiver.md
# serial_transceiver

Parametrised half-duplex serial transceiver for the shared GPIO game link. It replaces the separate transmitter/receiver pair and their divided minor/major clocks with one block on the system clock, using internal clock-enable ticks. Configurable data width, sample divider and oversampling ratio; adds false-start rejection, framing-error reporting and optional parity. Sits between the microprocessor's parallel PIO ports and the GPIO pad tri-state.

## Interface
- DATA_W, 8: payload bits per character, 5–16.
- SAMPLE_DIV, 128: clk cycles per sample tick, ≥2.
- OVERSAMPLE, 16: sample ticks per bit period, even, ≥4.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_W  character to send; captured on accepted load.
- load  in  1  request to send tx_data; level-sampled each clk.
- transmit_enable  in  1  1 = block may own the line and start frames.
- serial_in  in  1  line value from pad (asynchronous).
- serial_out  out  1  value driven onto line.
- serial_oe  out  1  pad output enable; 1 = drive serial_out.
- tx_busy  out  1  frame in progress.
- character_sent  out  1  one-clk pulse at end of transmitted frame.
- rx_data  out  DATA_W  last good received character; holds until next.
- character_received  out  1  one-clk pulse when rx_data updates.
- framing_error  out  1  one-clk pulse on bad stop (or parity) bit.

## Operation
- Frame: start (0), DATA_W bits LSB first, [parity], stop (1). Bit period T = SAMPLE_DIV×OVERSAMPLE clk.
- TX FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - load accepted only in IDLE with transmit_enable=1; otherwise ignored (no queueing).
  - Each state lasts exactly T clk via a TX bit timer cleared on accept; DATA lasts DATA_W×T.
  - transmit_enable falling mid-frame does not abort; frame completes.
- RX FSM: IDLE → START_CHK → DATA → [PARITY] → STOP → (WAIT_HIGH on error) → IDLE.
  - serial_in passes a 2-flop synchroniser; RX acts only on sample ticks (free-running divider).
  - RX is gated off while serial_oe=1 (no self-reception); held in IDLE.
  - IDLE: synced 0 on a tick → START_CHK. After OVERSAMPLE/2 ticks re-sample: 1 → false start, IDLE; 0 → DATA.
  - Subsequent bits sampled every OVERSAMPLE ticks (bit centre).
  - Stop = 1 (and parity good): rx_data loaded, character_received pulses. Stop = 0: framing_error pulses, rx_data unchanged, WAIT_HIGH until synced 1, then IDLE.
- Reset (any time, incl. mid-frame): both FSMs IDLE, counters zero.

## Timing
- Reset values: serial_out=1, serial_oe=0, tx_busy=0, character_sent=0, rx_data=0, character_received=0, framing_error=0.
- Accept at edge N: serial_oe=1, serial_out=0, tx_busy=1 from edge N+1.
- Stop bit ends at edge N+1+F×T (F = frame bits): serial_oe=0, tx_busy=0, serial_out=1, character_sent=1 for that one clk. Earliest new accept at that same edge's next cycle.
- serial_out is registered; no glitches between bits.
- RX: character_received/framing_error assert the clk after the stop-bit centre sample tick. Latency line edge→sample ≤ 2 clk sync + SAMPLE_DIV clk tick phase.
- Simultaneous load and incoming start bit: TX wins; RX stays IDLE once serial_oe rises.

## Configuration
- SERIAL_PARITY_EN defined: even-parity bit inserted after data (F = DATA_W+3); RX parity mismatch treated exactly as bad stop (framing_error, rx_data unchanged).
- Undefined: no parity state, F = DATA_W+2; no parity logic synthesised.

## Test plan
- SAMPLE_DIV=4, OVERSAMPLE=8, DATA_W=8: load 0xA5 → serial_oe high 10×32 clk, line 0,1,0,1,0,0,1,0,1,1 per 32 clk, single character_sent.
- Loopback second instance, send 0x3C → receiver rx_data=0x3C, one character_received, no framing_error.
- 8-clk low glitch on idle serial_in → returns IDLE, no pulses.
- Frame 0x55 with stop bit forced 0 → framing_error pulse, rx_data keeps prior value; next good 0x0F received.
- load held during busy and with transmit_enable=0 → only one frame sent; rst low at bit 4 → all outputs at reset values immediately, serial_oe=0.
- SERIAL_PARITY_EN: send 0x07 → parity bit 1, 11-bit frame; corrupt parity on RX → framing_error.
